i2s_tx: RTL
===========

Name: i2s_tx

Overview:
- I2S master transmitter. Sits directly downstream of the wishbone register interface and consumes its `prescaler` register output.
- Generates the bit clock (SCK) and word select (WS) from `wb_clk` using `prescaler`.
- Serializes stereo samples supplied over a valid/ready stream into SD.

Parameters:
- DW, 16, bits per channel; a frame is 2*DW bits (left then right).
- PW, 32, width of the prescaler input; matches the interface WB_DW.

Ports:
- wb_clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- prescaler  in  PW  SCK half-period minus one, in wb_clk cycles.
- enable  in  1  transmitter run enable.
- sample_i  in  2*DW  {left[DW-1:0], right[DW-1:0]}.
- sample_valid_i  in  1  sample_i is valid.
- sample_ready_o  out  1  holding buffer can accept a sample.
- i2s_sck_o  out  1  bit clock.
- i2s_ws_o  out  1  word select; 0 = left, 1 = right.
- i2s_sd_o  out  1  serial data, MSB first.
- underrun_o  out  1  one-cycle pulse when a frame starts with no sample available.

Behaviour:
- Clock and reset:
  - One clock, `wb_clk`. Reset `rst` is synchronous, active-high, and wins over all other inputs.
  - Reset values: sck=0, ws=0, sd=0, underrun_o=0, divider count=0, bit index b=2*DW-1, shift register=0, holding buffer empty.
- Divider:
  - While enable=1, `cnt` increments each cycle.
  - When cnt >= prescaler: cnt<=0 and sck toggles. Half-period = prescaler+1 cycles; prescaler=0 gives SCK = wb_clk/2.
  - Using >= means a reduced prescaler takes effect on the next cycle, never after a counter wrap.
- Edges: the 0->1 toggle is the rise event; the 1->0 toggle is the fall event. All outputs are registered and update in the same cycle as the sck toggle.
- On each fall event:
  - b <= (b == 2*DW-1) ? 0 : b+1.
  - ws <= 1 for new b in [DW-1, 2*DW-2], else 0. WS therefore leads the channel MSB by one bit.
  - sd <= shift_reg[2*DW-1-new_b].
- Frame load, when b wraps 2*DW-1 -> 0:
  - If the buffer is full: shift_reg <= buffer, buffer empties, sd shows the left MSB.
  - If the buffer is empty: shift_reg <= 0, sd=0, underrun_o=1 for exactly that cycle.
- Holding buffer (one entry):
  - sample_ready_o = !buffer_full, combinational.
  - Accept on sample_valid_i & sample_ready_o, regardless of enable.
  - Load and accept in the same cycle is possible only when the buffer was empty. That cycle signals an underrun, and the accepted sample fills the buffer for the next frame.
- enable=0:
  - Immediately forces cnt=0, sck=0, ws=0, sd=0, b=2*DW-1. Any frame in progress is abandoned.
  - Buffer contents are retained.
- enable 0->1:
  - First rise event occurs after prescaler+1 cycles.
  - The following fall event loads a frame at b=0.
- Reset mid-frame: all state returns to reset values on the next edge, including discarding the buffered sample.
- Steady-state throughput: one sample per 2*DW*2*(prescaler+1) cycles.

Decomposition:
- Package `i2s_pkg`:
  - DW default, FRAME_BITS = 2*DW.
  - Channel encoding constants WS_LEFT = 0, WS_RIGHT = 1.
- Sub-module `i2s_clkgen`:
  - Inputs: prescaler, enable.
  - Outputs: registered sck plus one-cycle rise/fall strobes.
  - Behaviour: the divider and edge rules above.
- `i2s_tx` holds the buffer, bit index, and shift logic.

Test Plan:
- Reset, then enable=1, prescaler=0, push 0xA5A50F0F:
  - sck period is 2 cycles; a frame is 64 cycles.
  - Left slot shows sd=1,0,1,0,0,1,0,1,... with ws=0; right slot shows 0x0F0F with ws=1.
  - ws rises one bit before the right MSB.
- prescaler=3:
  - sck high and low phases are exactly 4 cycles each.
  - Change to prescaler=1 mid-phase: the next toggle occurs within 1 cycle if cnt>=1, and phases are 2 cycles thereafter.
- No sample pushed with enable=1:
  - underrun_o pulses once per frame start, every 32 sck periods at DW=16.
  - sd stays 0.
- Back-to-back samples 0x12345678 then 0x9ABCDEF0 with valid held high:
  - ready drops after the first accept and rises in the frame-load cycle.
  - Frames are contiguous with no underrun.
- Drop enable at b=10:
  - sck/ws/sd go 0 on the next cycle.
  - The buffered sample is kept; on re-enable it is sent from the left MSB.
- Assert rst for 1 cycle mid-frame with the buffer full:
  - All outputs are 0 and sample_ready_o=1 the cycle after.
  - No stale data appears after re-enable.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared constants for the I2S transmitter: default channel width and
// word-select channel encoding.
package i2s_pkg;

   localparam int DW_DEFAULT = 16;
   localparam int FRAME_BITS = 2 * DW_DEFAULT;
   localparam int PW_DEFAULT = 32;

   localparam logic WS_LEFT  = 1'b0;
   localparam logic WS_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_clkgen.sv
// SCK divider: toggles SCK every prescaler+1 cycles while enabled and flags
// whether the current cycle produces a rising or falling SCK edge.
module i2s_clkgen #(
   parameter int PW = 32
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_enable,
   input  logic [PW-1:0] i_prescaler,
   output logic          o_sck,
   output logic          o_rise,
   output logic          o_fall
);

   logic [PW-1:0] r_cnt;
   logic          r_sck;
   logic          w_toggle;

   // >= so that a lowered prescaler takes effect at once instead of after a wrap
   assign w_toggle = i_enable && (r_cnt >= i_prescaler);
   assign o_rise   = w_toggle && !r_sck;
   assign o_fall   = w_toggle && r_sck;
   assign o_sck    = r_sck;

   always_ff @(posedge i_clk) begin
      if (i_rst || !i_enable) begin
         r_cnt <= '0;
         r_sck <= 1'b0;
      end else if (w_toggle) begin
         r_cnt <= '0;
         r_sck <= ~r_sck;
      end else begin
         r_cnt <= r_cnt + PW'(1);
      end
   end

endmodule

// File: rtl/i2s_tx.sv
// I2S master transmitter: one-entry sample holding buffer, frame bit index
// and serializer driven by the falling edges of the divided bit clock.
module i2s_tx
   import i2s_pkg::*;
#(
   parameter int DW = FRAME_BITS / 2,
   parameter int PW = PW_DEFAULT
) (
   input  logic            wb_clk,
   input  logic            rst,
   input  logic [PW-1:0]   prescaler,
   input  logic            enable,
   input  logic [2*DW-1:0] sample_i,
   input  logic            sample_valid_i,
   output logic            sample_ready_o,
   output logic            i2s_sck_o,
   output logic            i2s_ws_o,
   output logic            i2s_sd_o,
   output logic            underrun_o
);

   localparam int FW = 2 * DW;
   localparam int BW = (FW > 1) ? $clog2(FW) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(FW - 1);
   localparam logic [BW-1:0] WS_FIRST = BW'(DW - 1);
   localparam logic [BW-1:0] WS_LAST  = BW'(FW - 2);

   logic          w_rise;
   logic          w_fall;
   logic          w_fallEv;
   logic          w_accept;
   logic          w_load;
   logic [BW-1:0] w_nextB;
   logic [BW-1:0] w_sdIdx;
   logic          w_nextWs;

   logic [FW-1:0] r_buf;
   logic          r_full;
   logic [FW-1:0] r_shift;
   logic [BW-1:0] r_bitIdx;
   logic          r_ws;
   logic          r_sd;
   logic          r_underrun;
   logic          r_armed;

   i2s_clkgen #(
      .PW(PW)
   ) u_clkgen (
      .i_clk      (wb_clk),
      .i_rst      (rst),
      .i_enable   (enable),
      .i_prescaler(prescaler),
      .o_sck      (i2s_sck_o),
      .o_rise     (w_rise),
      .o_fall     (w_fall)
   );

   // A fall only counts once a rise has been seen since enable went high
   assign w_fallEv = w_fall && r_armed;
   assign w_accept = sample_valid_i && !r_full;
   assign w_load   = w_fallEv && (r_bitIdx == LAST_BIT);
   assign w_nextB  = (r_bitIdx == LAST_BIT) ? '0 : r_bitIdx + BW'(1);
   assign w_sdIdx  = LAST_BIT - w_nextB;
   // WS switches one bit ahead of the channel MSB
   assign w_nextWs = ((w_nextB >= WS_FIRST) && (w_nextB <= WS_LAST)) ? WS_RIGHT : WS_LEFT;

   assign sample_ready_o = !r_full;
   assign i2s_ws_o       = r_ws;
   assign i2s_sd_o       = r_sd;
   assign underrun_o     = r_underrun;

   // Accept and frame-load never collide: accept needs empty, load-drain needs full
   always_ff @(posedge wb_clk) begin
      if (rst) begin
         r_buf  <= '0;
         r_full <= 1'b0;
      end else if (w_accept) begin
         r_buf  <= sample_i;
         r_full <= 1'b1;
      end else if (w_load && r_full) begin
         r_full <= 1'b0;
      end
   end

   always_ff @(posedge wb_clk) begin
      if (rst || !enable) begin
         r_armed <= 1'b0;
      end else if (w_rise) begin
         r_armed <= 1'b1;
      end
   end

   always_ff @(posedge wb_clk) begin
      if (rst) begin
         r_shift    <= '0;
         r_bitIdx   <= LAST_BIT;
         r_ws       <= WS_LEFT;
         r_sd       <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_underrun <= 1'b0;
         if (!enable) begin
            r_bitIdx <= LAST_BIT;
            r_ws     <= WS_LEFT;
            r_sd     <= 1'b0;
         end else if (w_fallEv) begin
            r_bitIdx <= w_nextB;
            r_ws     <= w_nextWs;
            if (w_load) begin
               if (r_full) begin
                  r_shift <= r_buf;
                  r_sd    <= r_buf[FW-1];
               end else begin
                  r_shift    <= '0;
                  r_sd       <= 1'b0;
                  r_underrun <= 1'b1;
               end
            end else begin
               r_sd <= r_shift[w_sdIdx];
            end
         end
      end
   end

endmodule
